// File: rtl/alu_unit.sv
// Integer execute stage: one RV32I ALU / LUI / AUIPC / JAL / JALR / BRANCH op per cycle,
// with a single registered result broadcast back to the wakeup buses.
module alu_unit #(
    parameter int unsigned ROB_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                in_config,
    input  logic [31:0]         in_value_1,
    input  logic [31:0]         in_value_2,
    input  logic [31:0]         in_value_pc,
    input  logic [6:0]          in_opcode,
    input  logic [2:0]          in_precise,
    input  logic                in_more_precise,
    input  logic [31:0]         in_imm,
    input  logic [ROB_BITS-1:0] in_rob_entry,
    output logic                out_config,
    output logic [31:0]         out_val,
    output logic [ROB_BITS-1:0] out_rob_entry,
    output logic                out_is_jump,
    output logic                out_taken,
    output logic [31:0]         out_target_pc
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        do_sub;
    logic        do_sra;
    logic [31:0] alu_res;
    logic        br_taken;
    logic [31:0] pc_plus_4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;

    logic [31:0] res_val;
    logic        res_is_jump;
    logic        res_taken;
    logic [31:0] res_target;

    // Operand selection: OP-IMM replaces rs2 with the immediate; funct7[5] only selects
    // subtract for register ops, while it selects arithmetic shift for both forms.
    always_comb begin
        op_a   = in_value_1;
        op_b   = (in_opcode == OpcOp) ? in_value_2 : in_imm;
        shamt  = op_b[4:0];
        do_sub = (in_opcode == OpcOp) && in_more_precise;
        do_sra = in_more_precise;
    end

    // Integer ALU, decoded on funct3.
    always_comb begin
        alu_res = 32'h0;
        case (in_precise)
            3'b000:  alu_res = do_sub ? (op_a - op_b) : (op_a + op_b);
            3'b001:  alu_res = op_a << shamt;
            3'b010:  alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
            3'b011:  alu_res = {31'b0, (op_a < op_b)};
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = do_sra ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
            3'b110:  alu_res = op_a | op_b;
            3'b111:  alu_res = op_a & op_b;
            default: alu_res = 32'h0;
        endcase
    end

    // Branch condition on rs1/rs2; reserved funct3 codes never branch.
    always_comb begin
        br_taken = 1'b0;
        case (in_precise)
            3'b000:  br_taken = (in_value_1 == in_value_2);
            3'b001:  br_taken = (in_value_1 != in_value_2);
            3'b100:  br_taken = ($signed(in_value_1) < $signed(in_value_2));
            3'b101:  br_taken = ($signed(in_value_1) >= $signed(in_value_2));
            3'b110:  br_taken = (in_value_1 < in_value_2);
            3'b111:  br_taken = (in_value_1 >= in_value_2);
            default: br_taken = 1'b0;
        endcase
    end

    // PC arithmetic, all modulo 2^32.
    always_comb begin
        pc_plus_4   = in_value_pc + 32'd4;
        pc_plus_imm = in_value_pc + in_imm;
        jalr_sum    = in_value_1 + in_imm;
    end

    // Result mux by opcode; unknown opcodes still produce a result so the tag retires.
    always_comb begin
        res_val     = 32'h0;
        res_is_jump = 1'b0;
        res_taken   = 1'b0;
        res_target  = pc_plus_4;
        case (in_opcode)
            OpcOp, OpcOpImm: res_val = alu_res;
            OpcLui:          res_val = in_imm;
            OpcAuipc:        res_val = pc_plus_imm;
            OpcJal: begin
                res_val     = pc_plus_4;
                res_is_jump = 1'b1;
                res_taken   = 1'b1;
                res_target  = pc_plus_imm;
            end
            OpcJalr: begin
                res_val     = pc_plus_4;
                res_is_jump = 1'b1;
                res_taken   = 1'b1;
                res_target  = {jalr_sum[31:1], 1'b0};
            end
            OpcBranch: begin
                res_val     = {31'b0, br_taken};
                res_is_jump = 1'b1;
                res_taken   = br_taken;
                res_target  = br_taken ? pc_plus_imm : pc_plus_4;
            end
            default: begin
                res_val     = 32'h0;
                res_is_jump = 1'b0;
                res_taken   = 1'b0;
                res_target  = pc_plus_4;
            end
        endcase
    end

    // Output register: rollback kills the valid pulse even while frozen; payload holds
    // whenever no new op is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_config    <= 1'b0;
            out_val       <= 32'h0;
            out_rob_entry <= '0;
            out_is_jump   <= 1'b0;
            out_taken     <= 1'b0;
            out_target_pc <= 32'h0;
        end else if (rollback) begin
            out_config <= 1'b0;
        end else if (rdy) begin
            out_config <= in_config;
            if (in_config) begin
                out_val       <= res_val;
                out_rob_entry <= in_rob_entry;
                out_is_jump   <= res_is_jump;
                out_taken     <= res_taken;
                out_target_pc <= res_target;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit.
module tb_alu_unit;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        in_config;
    logic [31:0] in_value_1;
    logic [31:0] in_value_2;
    logic [31:0] in_value_pc;
    logic [6:0]  in_opcode;
    logic [2:0]  in_precise;
    logic        in_more_precise;
    logic [31:0] in_imm;
    logic [3:0]  in_rob_entry;
    logic        out_config;
    logic [31:0] out_val;
    logic [3:0]  out_rob_entry;
    logic        out_is_jump;
    logic        out_taken;
    logic [31:0] out_target_pc;

    int n_checks = 0;
    int n_errors = 0;

    alu_unit #(.ROB_BITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .in_config      (in_config),
        .in_value_1     (in_value_1),
        .in_value_2     (in_value_2),
        .in_value_pc    (in_value_pc),
        .in_opcode      (in_opcode),
        .in_precise     (in_precise),
        .in_more_precise(in_more_precise),
        .in_imm         (in_imm),
        .in_rob_entry   (in_rob_entry),
        .out_config     (out_config),
        .out_val        (out_val),
        .out_rob_entry  (out_rob_entry),
        .out_is_jump    (out_is_jump),
        .out_taken      (out_taken),
        .out_target_pc  (out_target_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic cfg, input logic [31:0] val,
                             input logic [3:0] rob, input logic jmp, input logic tk,
                             input logic [31:0] tgt);
        check({tag, ".cfg"}, {31'b0, out_config}, {31'b0, cfg});
        check({tag, ".val"}, out_val, val);
        check({tag, ".rob"}, {28'b0, out_rob_entry}, {28'b0, rob});
        check({tag, ".jmp"}, {31'b0, out_is_jump}, {31'b0, jmp});
        check({tag, ".tk"}, {31'b0, out_taken}, {31'b0, tk});
        check({tag, ".tgt"}, out_target_pc, tgt);
    endtask

    task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic mp,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [3:0] tag);
        in_opcode       = op;
        in_precise      = f3;
        in_more_precise = mp;
        in_value_1      = v1;
        in_value_2      = v2;
        in_value_pc     = pc;
        in_imm          = imm;
        in_rob_entry    = tag;
    endtask

    // Present one op across a single active edge, then sample 1ns later.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic mp,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [3:0] tag);
        @(negedge clk);
        set_op(op, f3, mp, v1, v2, pc, imm, tag);
        in_config = 1'b1;
        @(posedge clk);
        #1;
        in_config = 1'b0;
    endtask

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011;

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rollback = 1'b0;
        in_config = 1'b0;
        set_op(7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
        #12;
        check_out("reset", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // add with wrap, then pulse drop
        issue(OP, 3'b000, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'h40, 32'h0, 4'h3);
        check_out("add", 1'b1, 32'd5, 4'h3, 1'b0, 1'b0, 32'h44);
        @(posedge clk); #1;
        check("add_pulse", {31'b0, out_config}, 32'h0);

        issue(OP, 3'b000, 1'b1, 32'd7, 32'd9, 32'h0, 32'h0, 4'h1);
        check("sub", out_val, 32'hFFFF_FFFE);
        issue(OP, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 4'h2);
        check("sra", out_val, 32'hF800_0000);
        issue(OP, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 4'h2);
        check("srl", out_val, 32'h0800_0000);
        issue(OPI, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0, 32'h404, 4'h2);
        check("srai", out_val, 32'hF800_0000);
        issue(OPI, 3'b000, 1'b1, 32'd10, 32'd0, 32'h0, 32'd3, 4'h4);
        check("addi_no_sub", out_val, 32'd13);
        issue(OP, 3'b001, 1'b0, 32'h1, 32'h21, 32'h0, 32'h0, 4'h4);
        check("sll_5bit", out_val, 32'h2);
        issue(OP, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 4'h4);
        check("slt", out_val, 32'h1);
        issue(OP, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 4'h4);
        check("sltu", out_val, 32'h0);
        issue(OPI, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'h4);
        check("xori", out_val, 32'h0F0F_0F0F);
        issue(OP, 3'b110, 1'b0, 32'hF000_0000, 32'h0000_000F, 32'h0, 32'h0, 4'h4);
        check("or", out_val, 32'hF000_000F);
        issue(OP, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0, 4'h4);
        check("and", out_val, 32'h0F00_0F00);

        issue(LUI, 3'b000, 1'b0, 32'h0, 32'h0, 32'h300, 32'h1234_5000, 4'h5);
        check_out("lui", 1'b1, 32'h1234_5000, 4'h5, 1'b0, 1'b0, 32'h304);
        issue(AUI, 3'b000, 1'b0, 32'h0, 32'h0, 32'hFFFF_F000, 32'h0000_2000, 4'h6);
        check("auipc_wrap", out_val, 32'h0000_1000);
        issue(JAL, 3'b000, 1'b0, 32'h0, 32'h0, 32'h400, 32'hFFFF_FFF0, 4'h7);
        check_out("jal", 1'b1, 32'h404, 4'h7, 1'b1, 1'b1, 32'h3F0);
        issue(JALR, 3'b000, 1'b0, 32'h1003, 32'h0, 32'h200, 32'd4, 4'h8);
        check_out("jalr", 1'b1, 32'h204, 4'h8, 1'b1, 1'b1, 32'h1006);

        issue(BR, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'h9);
        check_out("blt", 1'b1, 32'h1, 4'h9, 1'b1, 1'b1, 32'h120);
        issue(BR, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'hA);
        check_out("bltu", 1'b1, 32'h0, 4'hA, 1'b1, 1'b0, 32'h104);
        issue(BR, 3'b000, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 4'hA);
        check("beq", {31'b0, out_taken}, 32'h1);
        issue(BR, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'hA);
        check("bge", {31'b0, out_taken}, 32'h0);
        issue(BR, 3'b010, 1'b0, 32'd1, 32'd2, 32'h100, 32'h20, 4'hB);
        check_out("br_undef", 1'b1, 32'h0, 4'hB, 1'b1, 1'b0, 32'h104);
        issue(7'b0001111, 3'b000, 1'b0, 32'd1, 32'd2, 32'h500, 32'h20, 4'hC);
        check_out("unknown", 1'b1, 32'h0, 4'hC, 1'b0, 1'b0, 32'h504);

        // Back-to-back with a 2-cycle freeze
        issue(OPI, 3'b000, 1'b0, 32'd1, 32'd0, 32'h0, 32'd1, 4'h1);
        check_out("b2b_a", 1'b1, 32'd2, 4'h1, 1'b0, 1'b0, 32'h4);
        issue(OPI, 3'b000, 1'b0, 32'd2, 32'd0, 32'h10, 32'd1, 4'h2);
        check_out("b2b_b", 1'b1, 32'd3, 4'h2, 1'b0, 1'b0, 32'h14);
        @(negedge clk);
        rdy = 1'b0;
        set_op(OPI, 3'b000, 1'b0, 32'd3, 32'd0, 32'h20, 32'd1, 4'h3);
        in_config = 1'b1;
        @(posedge clk); #1;
        check_out("frz1", 1'b1, 32'd3, 4'h2, 1'b0, 1'b0, 32'h14);
        @(posedge clk); #1;
        check_out("frz2", 1'b1, 32'd3, 4'h2, 1'b0, 1'b0, 32'h14);
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk); #1;
        in_config = 1'b0;
        check_out("b2b_c", 1'b1, 32'd4, 4'h3, 1'b0, 1'b0, 32'h24);
        @(posedge clk); #1;
        check("b2b_drop", {31'b0, out_config}, 32'h0);

        // Rollback discards the same-cycle issue
        @(negedge clk);
        set_op(OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 4'hD);
        in_config = 1'b1;
        rollback = 1'b1;
        @(posedge clk); #1;
        in_config = 1'b0;
        rollback = 1'b0;
        check("rb_issue", {31'b0, out_config}, 32'h0);

        // Rollback acts while frozen
        issue(OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 4'hE);
        check("rb_pre", {31'b0, out_config}, 32'h1);
        @(negedge clk);
        rdy = 1'b0;
        rollback = 1'b1;
        @(posedge clk); #1;
        check("rb_frozen", {31'b0, out_config}, 32'h0);
        rollback = 1'b0;
        rdy = 1'b1;

        // Asynchronous reset mid-stream
        issue(JAL, 3'b000, 1'b0, 32'h0, 32'h0, 32'h400, 32'h8, 4'hF);
        check("rst_pre", {31'b0, out_config}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check_out("rst_async", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
